// File: rtl/tune_ctrl_if.sv
// Phase-increment handoff from the tuning controller to the NCO.
// The master presents pinc with pinc_valid and the NCO accepts it with pinc_ready.
interface tune_ctrl_if #(
    parameter int PINC_WIDTH = 32
);
    logic [PINC_WIDTH-1:0] pinc;
    logic                  pinc_valid;
    logic                  pinc_ready;

    modport master (output pinc, output pinc_valid, input pinc_ready);
    modport slave  (input pinc, input pinc_valid, output pinc_ready);
endinterface

// File: rtl/tune_ctrl.sv
// Channel-tuning controller: debounced keys step or load a channel index and keep
// its NCO phase increment in step without a multiplier. Also drives two 7-segment digits.
module tune_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CH_MIN          = 0,
    parameter int CH_MAX          = 99,
    parameter int PINC_WIDTH      = 32,
    parameter int PINC_BASE       = 0,
    parameter int PINC_STEP       = 17179869
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_up_n,
    input  logic         key_down_n,
    input  logic         key_load_n,
    input  logic [6:0]   sw_preset,
    tune_ctrl_if.master  nco,
    output logic         busy,
    output logic [6:0]   channel,
    output logic [6:0]   hex0,
    output logic [6:0]   hex1
);
    localparam int K_UP   = 0;
    localparam int K_DOWN = 1;
    localparam int K_LOAD = 2;

    localparam int                    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]            CH_LO    = 7'(CH_MIN);
    localparam logic [6:0]            CH_HI    = 7'(CH_MAX);
    localparam logic [PINC_WIDTH-1:0] STEP     = PINC_WIDTH'(PINC_STEP);
    localparam logic [PINC_WIDTH-1:0] PINC_LO  =
        PINC_WIDTH'(64'(PINC_BASE) + 64'(CH_MIN) * 64'(PINC_STEP));
    localparam logic [PINC_WIDTH-1:0] PINC_HI  =
        PINC_WIDTH'(64'(PINC_BASE) + 64'(CH_MAX) * 64'(PINC_STEP));
    localparam logic [3:0] LO_ONES = 4'(CH_MIN % 10);
    localparam logic [3:0] LO_TENS = 4'(CH_MIN / 10);
    localparam logic [3:0] HI_ONES = 4'(CH_MAX % 10);
    localparam logic [3:0] HI_TENS = 4'(CH_MAX / 10);

    typedef enum logic [1:0] {IDLE, SEEK, SEND} state_t;

    logic [2:0]       raw_n;
    logic [2:0]       sync1_q, sync2_q, deb_q, press_q;
    logic [CNT_W-1:0] cnt_q [3];

    assign raw_n = {key_load_n, key_down_n, key_up_n};

    // NOTE: non-blocking assignments make sync1_q -> sync2_q a real two-flop chain;
    // blocking ones would collapse it into a single stage.
    // NOTE: the counter array is reset element by element so every key starts released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            press_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i]   <= '0;
                    deb_q[i]   <= sync2_q[i];
                    press_q[i] <= deb_q[i];  // pulse only on released -> pressed
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    state_t                state_q, state_d;
    logic [6:0]            channel_q, channel_d, target_q, target_d, sw_clamped;
    logic [PINC_WIDTH-1:0] pinc_q, pinc_d;
    logic [3:0]            ones_q, ones_d, tens_q, tens_d;
    logic [3:0]            up_ones, up_tens, dn_ones, dn_tens;

    assign up_ones = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
    assign up_tens = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
    assign dn_ones = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
    assign dn_tens = (ones_q == 4'd0) ? tens_q - 4'd1 : tens_q;

    always_comb begin
        if (int'(sw_preset) < CH_MIN)      sw_clamped = CH_LO;
        else if (int'(sw_preset) > CH_MAX) sw_clamped = CH_HI;
        else                               sw_clamped = sw_preset;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        channel_d = channel_q;
        target_d  = target_q;
        pinc_d    = pinc_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        unique case (state_q)
            IDLE: begin
                if (press_q[K_LOAD]) begin
                    target_d  = sw_clamped;
                    channel_d = CH_LO;
                    pinc_d    = PINC_LO;
                    ones_d    = LO_ONES;
                    tens_d    = LO_TENS;
                    state_d   = SEEK;
                end else if (press_q[K_UP]) begin
                    if (channel_q == CH_HI) begin
                        channel_d = CH_LO;
                        pinc_d    = PINC_LO;
                        ones_d    = LO_ONES;
                        tens_d    = LO_TENS;
                    end else begin
                        channel_d = channel_q + 7'd1;
                        pinc_d    = pinc_q + STEP;
                        ones_d    = up_ones;
                        tens_d    = up_tens;
                    end
                    state_d = SEND;
                end else if (press_q[K_DOWN]) begin
                    if (channel_q == CH_LO) begin
                        channel_d = CH_HI;
                        pinc_d    = PINC_HI;
                        ones_d    = HI_ONES;
                        tens_d    = HI_TENS;
                    end else begin
                        channel_d = channel_q - 7'd1;
                        pinc_d    = pinc_q - STEP;
                        ones_d    = dn_ones;
                        tens_d    = dn_tens;
                    end
                    state_d = SEND;
                end
            end
            SEEK: begin
                if (channel_q == target_q) begin
                    state_d = SEND;
                end else begin
                    channel_d = channel_q + 7'd1;
                    pinc_d    = pinc_q + STEP;
                    ones_d    = up_ones;
                    tens_d    = up_tens;
                end
            end
            SEND: begin
                if (nco.pinc_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset lands in SEND so the power-on channel is pushed to the NCO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEND;
            channel_q <= CH_LO;
            target_q  <= CH_LO;
            pinc_q    <= PINC_LO;
            ones_q    <= LO_ONES;
            tens_q    <= LO_TENS;
        end else begin
            state_q   <= state_d;
            channel_q <= channel_d;
            target_q  <= target_d;
            pinc_q    <= pinc_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign hex0           = seg7(ones_q);
    assign hex1           = seg7(tens_q);
    assign channel        = channel_q;
    assign busy           = (state_q != IDLE);
    assign nco.pinc       = pinc_q;
    assign nco.pinc_valid = (state_q == SEND);
endmodule

// File: doc/tune_ctrl.md
# tune_ctrl

Channel-tuning controller for the FM transmitter top level on the MAX10 board. It debounces the board push-buttons and steps a carrier channel index up or down, or loads it from the switches. It regenerates the matching NCO phase increment without a multiplier and hands it to the NCO over a valid/ready handshake. It also drives two active-low 7-segment digits with the current channel number.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable-low clocks required to accept a key press (10 ms at 50 MHz).
- CH_MIN, 0: lowest channel index. Constraint: 0 ≤ CH_MIN < CH_MAX ≤ 99.
- CH_MAX, 99: highest channel index.
- PINC_WIDTH, 32: phase-increment width.
- PINC_BASE, 0: phase increment for channel 0.
- PINC_STEP, 17179869: phase increment per channel (200 kHz at 50 MHz, 32 bits).
- clk  in  1  system clock (MAX10_CLK1_50 domain).
- rst  in  1  asynchronous, active-high reset.
- key_up_n  in  1  raw button, active-low, asynchronous to clk.
- key_down_n  in  1  raw button, active-low, asynchronous to clk.
- key_load_n  in  1  raw button, active-low, asynchronous to clk.
- sw_preset  in  7  channel to load; treated as static while load is pressed.
- pinc  out  PINC_WIDTH  phase increment for the current channel.
- pinc_valid  out  1  pinc holds a new value not yet accepted.
- pinc_ready  in  1  NCO accepts pinc when pinc_valid & pinc_ready.
- busy  out  1  high in SEEK or SEND; new key events are dropped while high.
- channel  out  7  current channel index, binary.
- hex0  out  7  ones digit, segments {g..a}, active-low.
- hex1  out  7  tens digit, segments {g..a}, active-low.

## Operation
- Each key passes through a 2-flop synchronizer and a per-key debounce counter.
  - The counter counts while the synced level differs from the debounced state and clears on any match.
  - At DEBOUNCE_CYCLES the debounced state flips.
  - A high-to-low debounced transition emits a one-cycle press pulse. Release emits nothing.
- FSM states: IDLE, SEEK, SEND.
- IDLE, press pulses are prioritised load > up > down. Same-cycle losers are dropped.
  - up: at CH_MAX, channel wraps to CH_MIN and pinc = PINC_BASE + CH_MIN·PINC_STEP. Otherwise channel+1 and pinc+PINC_STEP. Go to SEND.
  - down: at CH_MIN, channel wraps to CH_MAX and pinc = PINC_BASE + CH_MAX·PINC_STEP. Otherwise channel−1 and pinc−PINC_STEP. Go to SEND.
  - load: target = sw_preset clamped into [CH_MIN, CH_MAX] and latched. Set channel = CH_MIN and pinc = PINC_BASE + CH_MIN·PINC_STEP. Go to SEEK.
- SEEK: if channel == target, go to SEND. Otherwise channel+1 and pinc+PINC_STEP.
- SEND: pinc_valid = 1. When pinc_ready is high, go to IDLE.
- Endpoint pinc constants are elaboration-time; there is no runtime multiplier. pinc arithmetic is modulo 2^PINC_WIDTH.
- Press pulses arriving in SEEK or SEND are discarded. Debounce counters keep running.
- Tens and ones BCD digit registers update in the same cycle as channel: increment/decrement with carry/borrow, wrap load, and reset to CH_MIN digits.
- hex0 and hex1 are combinational decodes of the digit registers, 0–9 patterns only.

## Timing
- Reset, async assert:
  - FSM = SEND, channel = CH_MIN, pinc = PINC_BASE + CH_MIN·PINC_STEP, digits = CH_MIN.
  - pinc_valid = 1 and busy = 1 during and after reset, so the initial channel is pushed to the NCO.
  - Debounced states = released, counters = 0, synchronizers = 1.
- Key press: pulse at cycle 2 + DEBOUNCE_CYCLES after the raw input goes low and stays low.
- up/down: pulse in IDLE at cycle t; channel, pinc and pinc_valid all updated at t+1.
- load: pulse at t. SEEK is entered at t+1 with channel = CH_MIN. pinc_valid rises at t + 2 + (target − CH_MIN).
- Handshake: pinc_valid rises at t, pinc_ready is sampled high at cycle t' ≥ t, and pinc_valid is 0 from t'+1. pinc is stable while pinc_valid = 1.
- pinc_ready high in IDLE or SEEK has no effect.
- Reset mid-SEEK or mid-SEND aborts the operation and restores the reset values.

## Test plan
- Reset with pinc_ready = 0: pinc_valid = 1, channel = 0, pinc = 0, hex1 = hex0 = 7'b1000000. Raise pinc_ready: pinc_valid = 0 next cycle, busy = 0.
- DEBOUNCE_CYCLES = 4, up held 3 cycles then released: no change. Up held 10 cycles: channel = 1, pinc = 17179869, exactly one SEND.
- channel = 99, up: channel = 0, pinc = 0. Then down: channel = 99, pinc = 99·17179869 mod 2^32, hex1 = hex0 = 7'b0010000.
- sw_preset = 120, load: target clamped to 99. pinc_valid rises exactly 101 cycles after the load pulse. pinc = 1700807031. busy stays high throughout.
- Up and down pulses coincide in IDLE: only up is applied. Up pulse during SEND with pinc_ready = 0: dropped, and channel is unchanged after the handshake.
- Assert rst during SEEK at channel 37: channel = 0 immediately, pinc_valid = 1, and no further stepping occurs.
